// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes, result-source and forwarding selects.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM signal bundle for the execute stage.
// Optional branch counter ports (taken_cnt, cnt_clr) exist only when EX_BRANCH_CNT_EN is defined.
interface ex_stage_if #(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned REG_AW = 5
);
  logic              regwrite_E;
  logic [1:0]        result_src_E;
  logic              memwrite_E;
  logic              jump_E;
  logic              branch_E;
  logic [2:0]        alucontrol_E;
  logic              alusrc_E;
  logic [XLEN-1:0]   rd1_E;
  logic [XLEN-1:0]   rd2_E;
  logic [XLEN-1:0]   pc_E;
  logic [REG_AW-1:0] Rd_E;
  logic [XLEN-1:0]   immext_E;
  logic [XLEN-1:0]   pcplus4_E;
  logic [1:0]        forward_a_E;
  logic [1:0]        forward_b_E;
  logic [XLEN-1:0]   result_W;

  logic              pcsrc_E;
  logic [XLEN-1:0]   pctarget_E;
  logic              regwrite_M;
  logic [1:0]        result_src_M;
  logic              memwrite_M;
  logic [XLEN-1:0]   aluresult_M;
  logic [XLEN-1:0]   writedata_M;
  logic [REG_AW-1:0] Rd_M;
  logic [XLEN-1:0]   pcplus4_M;
`ifdef EX_BRANCH_CNT_EN
  logic              cnt_clr;
  logic [31:0]       taken_cnt;
`endif

  modport master (
    output regwrite_E, result_src_E, memwrite_E, jump_E, branch_E, alucontrol_E,
           alusrc_E, rd1_E, rd2_E, pc_E, Rd_E, immext_E, pcplus4_E,
           forward_a_E, forward_b_E, result_W,
`ifdef EX_BRANCH_CNT_EN
    output cnt_clr,
    input  taken_cnt,
`endif
    input  pcsrc_E, pctarget_E, regwrite_M, result_src_M, memwrite_M,
           aluresult_M, writedata_M, Rd_M, pcplus4_M
  );

  modport slave (
    input  regwrite_E, result_src_E, memwrite_E, jump_E, branch_E, alucontrol_E,
           alusrc_E, rd1_E, rd2_E, pc_E, Rd_E, immext_E, pcplus4_E,
           forward_a_E, forward_b_E, result_W,
`ifdef EX_BRANCH_CNT_EN
    input  cnt_clr,
    output taken_cnt,
`endif
    output pcsrc_E, pctarget_E, regwrite_M, result_src_M, memwrite_M,
           aluresult_M, writedata_M, Rd_M, pcplus4_M
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU: add, sub (A + ~B + 1), and, or, signed slt; others give 0.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [2:0]      alucontrol,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Operation select; unlisted encodings produce zero.
  always_comb begin
    result = '0;
    case (alu_op_e'(alucontrol))
      ALU_ADD: result = srca + srcb;
      ALU_SUB: result = srca + ~srcb + {{(XLEN-1){1'b0}}, 1'b1};
      ALU_AND: result = srca & srcb;
      ALU_OR:  result = srca | srcb;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, branch/jump resolution and the EX/MEM register.
// Optional macro EX_BRANCH_CNT_EN adds a saturating taken-redirect counter (taken_cnt, cnt_clr).
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned REG_AW = 5
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] srcb;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // Operand A / store-data forwarding; the illegal select 11 yields zero.
  always_comb begin
    srca  = '0;
    wdata = '0;
    case (fwd_sel_e'(bus.forward_a_E))
      FWD_RF:  srca = bus.rd1_E;
      FWD_W:   srca = bus.result_W;
      FWD_M:   srca = bus.aluresult_M;
      default: srca = '0;
    endcase
    case (fwd_sel_e'(bus.forward_b_E))
      FWD_RF:  wdata = bus.rd2_E;
      FWD_W:   wdata = bus.result_W;
      FWD_M:   wdata = bus.aluresult_M;
      default: wdata = '0;
    endcase
  end

  assign srcb = bus.alusrc_E ? bus.immext_E : wdata;

  alu #(.XLEN(XLEN)) u_alu (
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (bus.alucontrol_E),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  assign bus.pcsrc_E    = (bus.branch_E & alu_zero) | bus.jump_E;
  assign bus.pctarget_E = bus.pc_E + bus.immext_E;

  // EX/MEM pipeline register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.regwrite_M   <= 1'b0;
      bus.result_src_M <= '0;
      bus.memwrite_M   <= 1'b0;
      bus.aluresult_M  <= '0;
      bus.writedata_M  <= '0;
      bus.Rd_M         <= '0;
      bus.pcplus4_M    <= '0;
    end else begin
      bus.regwrite_M   <= bus.regwrite_E;
      bus.result_src_M <= bus.result_src_E;
      bus.memwrite_M   <= bus.memwrite_E;
      bus.aluresult_M  <= alu_result;
      bus.writedata_M  <= wdata;
      bus.Rd_M         <= bus.Rd_E;
      bus.pcplus4_M    <= bus.pcplus4_E;
    end
  end

  // Flag the illegal forwarding select while out of reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (bus.forward_a_E != 2'b11 && bus.forward_b_E != 2'b11)
        else $error("illegal forwarding select 11");
    end
  end

`ifdef EX_BRANCH_CNT_EN
  logic [31:0] cnt_q;

  // Redirect counter: clear beats increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (bus.pcsrc_E && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.taken_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_stage;

  logic clk;
  logic rst_n;

  ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  ex_stage #(.XLEN(32), .REG_AW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regwrite;
    logic [1:0]  rsrc;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic [2:0]  op;
    logic        alusrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] rw;
  } ex_in_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // model state: value the previous instruction left in aluresult_M
  logic [31:0] m_alu = '0;
  logic        obs_pcsrc;
  logic [31:0] obs_target;
  logic [31:0] model_cnt = '0;
  logic        cnt_clr_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  function automatic ex_in_t nop();
    ex_in_t v;
    v.regwrite = 0; v.rsrc = 0; v.memwrite = 0; v.jump = 0; v.branch = 0; v.op = 0;
    v.alusrc = 0; v.rd1 = 0; v.rd2 = 0; v.pc = 0; v.rd = 0; v.imm = 0; v.pc4 = 0;
    v.fa = 0; v.fb = 0; v.rw = 0;
    return v;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                       input logic [31:0] w, input logic [31:0] m);
    if (s == 2'd0) return rf;
    if (s == 2'd1) return w;
    if (s == 2'd2) return m;
    return 32'd0;
  endfunction

  // Reference ALU; signed compare done by biasing the sign bit into an unsigned compare.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ba, bb;
    ba = a ^ 32'h8000_0000;
    bb = b ^ 32'h8000_0000;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (ba < bb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input ex_in_t v);
    bus.regwrite_E   = v.regwrite;
    bus.result_src_E = v.rsrc;
    bus.memwrite_E   = v.memwrite;
    bus.jump_E       = v.jump;
    bus.branch_E     = v.branch;
    bus.alucontrol_E = v.op;
    bus.alusrc_E     = v.alusrc;
    bus.rd1_E        = v.rd1;
    bus.rd2_E        = v.rd2;
    bus.pc_E         = v.pc;
    bus.Rd_E         = v.rd;
    bus.immext_E     = v.imm;
    bus.pcplus4_E    = v.pc4;
    bus.forward_a_E  = v.fa;
    bus.forward_b_E  = v.fb;
    bus.result_W     = v.rw;
  endtask

  // One instruction: starts just after a rising edge, ends just after the next one.
  task automatic run_cycle(input string tag, input ex_in_t v);
    logic [31:0] a, wd, b, res;
    logic        exp_pcsrc;
    drive(v);
`ifdef EX_BRANCH_CNT_EN
    bus.cnt_clr = cnt_clr_v;
`endif
    #1;
    a   = pick(v.fa, v.rd1, v.rw, m_alu);
    wd  = pick(v.fb, v.rd2, v.rw, m_alu);
    b   = v.alusrc ? v.imm : wd;
    res = ref_alu(v.op, a, b);
    exp_pcsrc  = (v.branch && res == 32'd0) || v.jump;
    obs_pcsrc  = bus.pcsrc_E;
    obs_target = bus.pctarget_E;
    check({tag, ".pcsrc"}, {31'd0, obs_pcsrc}, {31'd0, exp_pcsrc});
    check({tag, ".pctarget"}, obs_target, v.pc + v.imm);
    @(posedge clk);
    #1;
    m_alu = res;
    check({tag, ".aluresult_M"}, bus.aluresult_M, res);
    check({tag, ".writedata_M"}, bus.writedata_M, wd);
    check({tag, ".ctrl_M"},
          {26'd0, bus.regwrite_M, bus.result_src_M, bus.memwrite_M, bus.Rd_M[1:0]},
          {26'd0, v.regwrite, v.rsrc, v.memwrite, v.rd[1:0]});
    check({tag, ".Rd_M"}, {27'd0, bus.Rd_M}, {27'd0, v.rd});
    check({tag, ".pcplus4_M"}, bus.pcplus4_M, v.pc4);
`ifdef EX_BRANCH_CNT_EN
    if (cnt_clr_v) model_cnt = 32'd0;
    else if (exp_pcsrc && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    check({tag, ".taken_cnt"}, bus.taken_cnt, model_cnt);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    ex_in_t v;
    rst_n = 1'b0;
    drive(nop());
`ifdef EX_BRANCH_CNT_EN
    bus.cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset.aluresult_M", bus.aluresult_M, 32'd0);
    check("reset.ctrl_M", {29'd0, bus.regwrite_M, bus.memwrite_M, bus.result_src_M == 2'd0},
          32'd1);
    rst_n = 1'b1;

    // 2: add with W-forward on A
    v = nop(); v.rd1 = 5; v.rw = 7; v.fa = 2'b01; v.alusrc = 1; v.imm = 3; v.op = 3'b000;
    v.regwrite = 1; v.rd = 5'd3; v.pc4 = 32'h104;
    run_cycle("t2", v);
    check("t2.add_fwd_w", bus.aluresult_M, 32'd10);

    // 3: back-to-back M-forward chain
    v = nop(); v.rd1 = 1; v.imm = 2; v.alusrc = 1; v.op = 3'b000;
    run_cycle("t3a", v);
    v = nop(); v.fa = 2'b10; v.imm = 4; v.alusrc = 1; v.op = 3'b000; v.rd1 = 32'hDEAD;
    run_cycle("t3b", v);
    check("t3.chain", bus.aluresult_M, 32'd7);

    // 4: beq taken and not taken
    v = nop(); v.rd1 = 9; v.rd2 = 9; v.op = 3'b001; v.branch = 1; v.pc = 32'h100;
    v.imm = 32'hFFFF_FFF8;
    run_cycle("t4a", v);
    check("t4.taken", {31'd0, obs_pcsrc}, 32'd1);
    check("t4.target", obs_target, 32'h0000_00F8);
    v.rd2 = 8;
    run_cycle("t4b", v);
    check("t4.not_taken", {31'd0, obs_pcsrc}, 32'd0);

    // 5: slt, add wrap with zero, store forwarding from W
    v = nop(); v.rd1 = 32'hFFFF_FFFF; v.imm = 1; v.alusrc = 1; v.op = 3'b101;
    run_cycle("t5a", v);
    check("t5.slt", bus.aluresult_M, 32'd1);
    v.op = 3'b000; v.branch = 1;
    run_cycle("t5b", v);
    check("t5.wrap", bus.aluresult_M, 32'd0);
    check("t5.zero", {31'd0, obs_pcsrc}, 32'd1);
    v = nop(); v.fb = 2'b01; v.alusrc = 1; v.rw = 32'h1234_5678; v.rd2 = 32'h1111;
    v.memwrite = 1; v.imm = 8;
    run_cycle("t5c", v);
    check("t5.store", bus.writedata_M, 32'h1234_5678);

    // 1: reset mid-run, then normal load after release
    v = nop(); v.regwrite = 1; v.rd1 = 32'h55; v.alusrc = 1; v.imm = 1; v.rd = 5'd9;
    v.pc4 = 32'h40; v.memwrite = 1;
    run_cycle("t1pre", v);
    #2 rst_n = 1'b0;
    #1;
    check("t1.async_alu", bus.aluresult_M, 32'd0);
    check("t1.async_ctl", {26'd0, bus.regwrite_M, bus.memwrite_M, bus.Rd_M}, 32'd0);
    check("t1.async_pc4", bus.pcplus4_M, 32'd0);
    m_alu = '0;
    model_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_cycle("t1post", v);
    check("t1.reload", bus.aluresult_M, 32'h56);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      v.regwrite = 1'($urandom);
      v.rsrc     = 2'($urandom_range(0, 2));
      v.memwrite = 1'($urandom);
      v.jump     = ($urandom_range(0, 7) == 0);
      v.branch   = 1'($urandom);
      v.op       = 3'($urandom);
      v.alusrc   = 1'($urandom);
      v.rd1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.rd2      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.pc       = $urandom;
      v.rd       = 5'($urandom);
      v.imm      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.pc4      = v.pc + 32'd4;
      v.fa       = 2'($urandom_range(0, 2));
      v.fb       = 2'($urandom_range(0, 2));
      v.rw       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_cycle("rand", v);
    end

`ifdef EX_BRANCH_CNT_EN
    // 6: counter increment, clear priority, saturation
    cnt_clr_v = 1'b1;
    run_cycle("t6clr0", nop());
    cnt_clr_v = 1'b0;
    v = nop(); v.jump = 1;
    repeat (3) run_cycle("t6inc", v);
    check("t6.three", bus.taken_cnt, 32'd3);
    cnt_clr_v = 1'b1;
    run_cycle("t6clr", v);
    check("t6.clr_prio", bus.taken_cnt, 32'd0);
    cnt_clr_v = 1'b0;
    force u_dut.cnt_q = 32'hFFFF_FFFF;
    #1 release u_dut.cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    run_cycle("t6sat", v);
    check("t6.saturate", bus.taken_cnt, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
